// File: rtl/fault_campaign_ctrl_if.sv
// Handshake and test-vector bundle between the fault campaign controller and the
// comparator-under-test / result consumer.
interface fault_campaign_ctrl_if #(
    parameter int unsigned NG = 128
);
    localparam int unsigned GW = (NG > 1) ? $clog2(NG) : 1;
    localparam int unsigned CW = $clog2(2 * NG + 1);

    logic          start;
    logic          eq_err;
    logic [1:0]    X;
    logic [1:0]    Y;
    logic [NG-1:0] fault_en_bus;
    logic          fault_val;
    logic          busy;
    logic          done;
    logic          res_valid;
    logic          res_ready;
    logic [GW-1:0] res_gid;
    logic          res_fval;
    logic [3:0]    res_mism;
    logic          res_det;
    logic [CW-1:0] det_cnt;

    // master: the controller; slave: the comparator model and result sink.
    modport master (
        input  start,
        input  eq_err,
        input  res_ready,
        output X,
        output Y,
        output fault_en_bus,
        output fault_val,
        output busy,
        output done,
        output res_valid,
        output res_gid,
        output res_fval,
        output res_mism,
        output res_det,
        output det_cnt
    );

    modport slave (
        output start,
        output eq_err,
        output res_ready,
        input  X,
        input  Y,
        input  fault_en_bus,
        input  fault_val,
        input  busy,
        input  done,
        input  res_valid,
        input  res_gid,
        input  res_fval,
        input  res_mism,
        input  res_det,
        input  det_cnt
    );
endinterface

// File: rtl/fault_campaign_ctrl.sv
// Fault-injection campaign sequencer: sweeps every (gate, value) fault over all nine
// mod-3 operand pairs and reports the mismatch count of each fault.
module fault_campaign_ctrl #(
    parameter int unsigned NG = 128
) (
    input logic                  clk,
    input logic                  rst_n,
    fault_campaign_ctrl_if.master bus
);
    localparam int unsigned GW = (NG > 1) ? $clog2(NG) : 1;
    localparam int unsigned CW = $clog2(2 * NG + 1);

    typedef enum logic [1:0] {StIdle, StRun, StReport, StFin} state_e;

    state_e        state_q;
    logic [1:0]    x_q;
    logic [1:0]    y_q;
    logic [NG-1:0] fen_q;
    logic          fval_q;
    logic [GW-1:0] gid_q;
    logic [3:0]    mism_q;
    logic          busy_q;
    logic          done_q;
    logic          rvalid_q;
    logic [GW-1:0] rgid_q;
    logic          rfval_q;
    logic [3:0]    rmism_q;
    logic          rdet_q;
    logic [CW-1:0] det_q;

    logic          golden;
    logic [3:0]    mism_d;
    logic          last_vec;
    logic          last_fault;
    logic [GW-1:0] gid_adv;
    logic [NG-1:0] onehot_adv;

    always_comb begin
        golden     = (x_q != y_q);
        mism_d     = mism_q;
        if ((bus.eq_err != golden) && (mism_q != 4'd9)) begin
            mism_d = mism_q + 4'd1;
        end
        last_vec   = (x_q == 2'd2) && (y_q == 2'd2);
        last_fault = (gid_q == GW'(NG - 1)) && fval_q;
        // Gate of the fault that follows the current one; gid 0 when idle.
        gid_adv    = fval_q ? gid_q + GW'(1) : gid_q;
        onehot_adv = '0;
        for (int unsigned i = 0; i < NG; i++) begin
            if (GW'(i) == gid_adv) begin
                onehot_adv[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            x_q      <= '0;
            y_q      <= '0;
            fen_q    <= '0;
            fval_q   <= 1'b0;
            gid_q    <= '0;
            mism_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rgid_q   <= '0;
            rfval_q  <= 1'b0;
            rmism_q  <= '0;
            rdet_q   <= 1'b0;
            det_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                        det_q   <= '0;
                        x_q     <= '0;
                        y_q     <= '0;
                        mism_q  <= '0;
                        fen_q   <= onehot_adv;
                    end
                end
                StRun: begin
                    mism_q <= mism_d;
                    if (last_vec) begin
                        state_q  <= StReport;
                        rvalid_q <= 1'b1;
                        rgid_q   <= gid_q;
                        rfval_q  <= fval_q;
                        rmism_q  <= mism_d;
                        rdet_q   <= (mism_d != 4'd0);
                        fen_q    <= '0;
                        x_q      <= '0;
                        y_q      <= '0;
                    end else if (y_q == 2'd2) begin
                        y_q <= '0;
                        x_q <= x_q + 2'd1;
                    end else begin
                        y_q <= y_q + 2'd1;
                    end
                end
                StReport: begin
                    if (bus.res_ready) begin
                        rvalid_q <= 1'b0;
                        det_q    <= det_q + CW'(rdet_q);
                        mism_q   <= '0;
                        if (last_fault) begin
                            state_q <= StFin;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            gid_q   <= '0;
                            fval_q  <= 1'b0;
                        end else begin
                            state_q <= StRun;
                            gid_q   <= gid_adv;
                            fval_q  <= ~fval_q;
                            fen_q   <= onehot_adv;
                        end
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.X            = x_q;
    assign bus.Y            = y_q;
    assign bus.fault_en_bus = fen_q;
    assign bus.fault_val    = fval_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.res_valid    = rvalid_q;
    assign bus.res_gid      = rgid_q;
    assign bus.res_fval     = rfval_q;
    assign bus.res_mism     = rmism_q;
    assign bus.res_det      = rdet_q;
    assign bus.det_cnt      = det_q;
endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Directed bench for fault_campaign_ctrl: NG=4 campaigns under several comparator models,
// a result stall, a mid-run reset, a start re-pulse, plus an NG=1 instance.
module tb_fault_campaign_ctrl;
    localparam int unsigned NG = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   mode = 0;

    always #5 clk = ~clk;

    fault_campaign_ctrl_if #(.NG(NG)) bus ();
    fault_campaign_ctrl_if #(.NG(1))  bus1 ();

    fault_campaign_ctrl #(.NG(NG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    fault_campaign_ctrl #(.NG(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.master)
    );

    // Comparator models: 0 golden, 1 stuck-at-1, 2 golden inverted only for fault (gid 2, val 1).
    always_comb begin
        unique case (mode)
            1:       bus.eq_err = 1'b1;
            2:       bus.eq_err = (bus.X != bus.Y) ^ (bus.fault_en_bus[2] & bus.fault_val);
            default: bus.eq_err = (bus.X != bus.Y);
        endcase
    end
    assign bus1.eq_err    = 1'b1;
    assign bus1.res_ready = 1'b1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] all_outs();
        return {bus.X, bus.Y, bus.fault_en_bus, bus.fault_val, bus.busy, bus.done,
                bus.res_valid, bus.res_gid, bus.res_fval, bus.res_mism, bus.res_det,
                bus.det_cnt};
    endfunction

    function automatic int exp_mism(input int m, input int idx);
        if (m == 1) return 3;
        if (m == 2) return (idx == 5) ? 9 : 0;
        return 0;
    endfunction

    task automatic run_campaign(input string tag, input int stall, input bit repulse);
        int busy_cnt = 0;
        int done_cnt = 0;
        int nrep = 0;
        int exp_det = 0;
        int stall_left = stall;
        bit fin = 1'b0;
        bit snapped = 1'b0;
        logic [8:0] snap = '0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_detclr"}, 64'(bus.det_cnt), 64'd0);
        for (int c = 0; c < 300 && !fin; c++) begin
            if (c > 0) @(negedge clk);
            if (repulse) bus.start = (c == 30 || c == 31 || c == 79);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                fin = 1'b1;
                check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
            end
            if (bus.res_valid && nrep == 0 && stall > 0) begin
                if (!snapped) begin
                    snap    = {bus.res_valid, bus.res_gid, bus.res_fval, bus.res_mism, bus.res_det};
                    snapped = 1'b1;
                end else begin
                    check({tag, "_stall_hold"}, 64'({bus.res_valid, bus.res_gid, bus.res_fval,
                          bus.res_mism, bus.res_det}), 64'(snap));
                end
            end
            if (bus.res_valid && nrep == 0 && stall_left > 0) begin
                bus.res_ready = 1'b0;
                stall_left--;
            end else begin
                bus.res_ready = 1'b1;
            end
            if (bus.res_valid && bus.res_ready) begin
                check($sformatf("%s_gid%0d", tag, nrep), 64'(bus.res_gid), 64'(nrep / 2));
                check($sformatf("%s_fval%0d", tag, nrep), 64'(bus.res_fval), 64'(nrep % 2));
                check($sformatf("%s_mism%0d", tag, nrep), 64'(bus.res_mism),
                      64'(exp_mism(mode, nrep)));
                check($sformatf("%s_det%0d", tag, nrep), 64'(bus.res_det),
                      64'(exp_mism(mode, nrep) != 0));
                if (exp_mism(mode, nrep) != 0) exp_det++;
                nrep++;
            end
        end
        bus.start     = 1'b0;
        bus.res_ready = 1'b1;
        check({tag, "_finished"}, 64'(fin), 64'd1);
        check({tag, "_nrep"}, 64'(nrep), 64'd8);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(80 + stall));
        check({tag, "_done_cycles"}, 64'(done_cnt), 64'd1);
        check({tag, "_det_cnt"}, 64'(bus.det_cnt), 64'(exp_det));
        repeat (3) @(negedge clk);
        check({tag, "_done_low"}, 64'(bus.done), 64'd0);
        check({tag, "_det_hold"}, 64'(bus.det_cnt), 64'(exp_det));
    endtask

    initial begin
        int busy1 = 0;
        int rep1 = 0;
        int gidbad1 = 0;
        bus.start     = 1'b0;
        bus.res_ready = 1'b1;
        bus1.start    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", 64'(all_outs()), 64'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_wait", 64'({bus.busy, bus.res_valid, bus.done}), 64'd0);

        mode = 0;
        run_campaign("golden", 0, 1'b0);
        mode = 1;
        run_campaign("stuck1", 0, 1'b0);
        mode = 2;
        run_campaign("inv_g2v1", 0, 1'b0);
        mode = 0;
        run_campaign("stall5", 5, 1'b0);
        run_campaign("repulse", 0, 1'b1);

        // Reset in the third fault's RUN (gid 1, val 0), after two stuck-at detections.
        mode = 1;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (23) @(negedge clk);
        check("midrun_fen", 64'(bus.fault_en_bus), 64'h2);
        check("midrun_det", 64'(bus.det_cnt), 64'd2);
        #2 rst_n = 1'b0;
        #1 check("midrun_reset_outs", 64'(all_outs()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_idle", 64'({bus.busy, bus.res_valid, bus.done}), 64'd0);
        run_campaign("postrst", 0, 1'b0);

        // NG = 1: two faults, both on gate 0, stuck-at-1 comparator.
        @(negedge clk);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk);
            if (bus1.busy) busy1++;
            if (bus1.res_valid) begin
                rep1++;
                if (bus1.res_gid != 1'b0) gidbad1++;
            end
        end
        check("ng1_busy", 64'(busy1), 64'd20);
        check("ng1_reports", 64'(rep1), 64'd2);
        check("ng1_gid", 64'(gidbad1), 64'd0);
        check("ng1_det_cnt", 64'(bus1.det_cnt), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fault_campaign_ctrl.md
FAULT_CAMPAIGN_CTRL -- requirements
Module: fault_campaign_ctrl

Interface
REQ-001 The block SHALL have parameter NG, default 128, giving the width of fault_en_bus and the number of injectable gate IDs; NG >= 1.
REQ-002 The block SHALL have localparam GW = max(1, clog2(NG)), the gate-ID width, and localparam CW = clog2(2*NG+1), the detection-counter width.
REQ-003 clk  input  1  single clock; every register updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  campaign start request, sampled only in IDLE.
REQ-006 eq_err  input  1  comparator output under test (combinational in X/Y/fault controls).
REQ-007 X, Y  output  2 each  mod-3 residue operands driven to the comparator.
REQ-008 fault_en_bus  output  NG  one-hot fault enable for the current gate ID; all-zero when not injecting.
REQ-009 fault_val  output  1  injected value for the current fault.
REQ-010 busy  output  1  high while the campaign runs (RUN or REPORT).
REQ-011 done  output  1  one-cycle pulse when the campaign completes.
REQ-012 res_valid / res_ready  output / input  1 / 1  per-fault result handshake.
REQ-013 res_gid  output  GW  gate ID of the reported fault.
REQ-014 res_fval  output  1  fault_val of the reported fault.
REQ-015 res_mism  output  4  number of mismatching vectors (0..9).
REQ-016 res_det  output  1  high when res_mism != 0.
REQ-017 det_cnt  output  CW  running count of detected faults.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, REPORT and FIN, and all outputs SHALL be registered.
- IDLE -> RUN when start = 1.
- RUN -> REPORT after the 9th vector.
- REPORT -> RUN, or -> FIN after the last fault, on res_valid & res_ready.
- FIN -> IDLE unconditionally after 1 cycle; done = 1 in FIN only.
REQ-019 The fault order SHALL be gid 0..NG-1 outer and fault_val 0 then 1 inner, giving 2*NG faults in total.
REQ-020 In RUN the block SHALL present one vector per cycle, X = 0..2 outer and Y = 0..2 inner; residue 3 is never driven.
- fault_en_bus = (1 << gid) and fault_val = the current value throughout RUN.
REQ-021 eq_err SHALL be compared at the clock edge ending each RUN cycle against golden = (X != Y); each mismatch increments the per-fault mismatch counter, saturating at 9.
REQ-022 On entry to REPORT:
- res_valid = 1.
- res_gid, res_fval, res_mism and res_det are set and held stable until the handshake.
- fault_en_bus = 0 while in REPORT.
REQ-023 The handshake SHALL complete on the edge where res_valid & res_ready are both 1.
- On that edge: res_valid drops, det_cnt += res_det, the mismatch counter clears and the fault index advances.
- res_ready may be held high; REPORT then lasts exactly 1 cycle.
REQ-024 The campaign SHALL last exactly 20*NG cycles of busy when res_ready is held high, and each cycle of res_ready low SHALL add exactly one cycle.
REQ-025 start SHALL be ignored in RUN, REPORT and FIN, and a new start in IDLE SHALL clear det_cnt on the same edge the block enters RUN.
REQ-026 det_cnt SHALL hold its final value in IDLE until the next start.
REQ-027 For NG = 1 the block SHALL run exactly 2 faults, both with gid 0.

Reset
REQ-028 While rst_n = 0, or any time it is asserted, including mid-RUN or mid-REPORT, the block SHALL immediately take these values:
- State = IDLE.
- X = Y = 0, fault_en_bus = 0, fault_val = 0.
- busy = done = res_valid = 0.
- res_gid = res_fval = res_mism = res_det = 0.
- det_cnt = 0 and all internal counters = 0.
REQ-029 After rst_n deasserts, the block SHALL wait in IDLE for start; no partial result is emitted.

Verification
REQ-030 Golden model on eq_err (eq_err = X != Y), NG = 4, res_ready = 1, start pulse:
- 8 reports, all with res_mism = 0.
- det_cnt = 0.
- busy high exactly 80 cycles, then done high 1 cycle.
REQ-031 eq_err stuck at 1, NG = 4:
- Every report has res_mism = 3 and res_det = 1.
- Final det_cnt = 8.
REQ-032 Model that inverts eq_err only when fault_en_bus[2] = 1 and fault_val = 1, NG = 4:
- Only the report with gid = 2, fval = 1 is detected, with res_mism = 9.
- Final det_cnt = 1.
REQ-033 res_ready = 0 for 5 cycles during the first REPORT:
- res_valid and all res_* fields hold stable during the stall.
- Total busy length = 85 cycles.
REQ-034 rst_n pulled low during the 3rd fault's RUN:
- All outputs read 0 immediately.
- A later start runs a full campaign from gid 0 with det_cnt starting at 0.
REQ-035 start pulsed again while busy:
- No effect.
- Report sequence and cycle count are identical to REQ-030.
